uart_tx_flow: RTL and testbench
===============================

Name: uart_tx_flow

Overview:
Buffered UART transmitter with hardware flow control. It is the transmit-side counterpart to the serial receive path on the Nexys A7 board. Logic writes bytes into an internal FIFO; the block serialises them as 8N1 frames on the TX pin, and only starts a new frame while the peer asserts clear-to-send.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz.
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated (868 at defaults); must be >= 4.
FIFO_DEPTH, 16, byte entries; power of two, >= 2.

Ports:
CLK_100_I  in  1  system clock; every register is clocked on its rising edge.
RST_I  in  1  asynchronous, active-high reset.
BYTE_I  in  8  byte to enqueue.
WR_I  in  1  write strobe; enqueues BYTE_I when FULL_O=0.
CTS_I  in  1  peer ready (active-high); asynchronous, so it passes through a 2-flop synchroniser.
SERIAL_O  out  1  UART TX line; idles high.
FULL_O  out  1  FIFO holds FIFO_DEPTH entries.
LEVEL_O  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
BUSY_O  out  1  a frame is in progress.
DONE_O  out  1  one-cycle pulse in the last clock of each stop bit.
OVF_O  out  1  sticky; set when WR_I arrives while FULL_O=1.

Behaviour:
- Reset: asynchronous, active-high.
  - Outputs on reset: SERIAL_O=1, FULL_O=0, LEVEL_O=0, BUSY_O=0, DONE_O=0, OVF_O=0.
  - FIFO pointers, bit counter, baud counter and CTS synchroniser all clear.
  - Reset mid-frame aborts the frame: the line returns high immediately and FIFO contents are discarded.
- FIFO writes:
  - WR_I with FULL_O=0 stores BYTE_I; LEVEL_O increments after that edge.
  - WR_I with FULL_O=1 drops the byte and sets OVF_O. A pop in the same cycle does not rescue the write, because FULL_O is evaluated on pre-edge occupancy.
  - Simultaneous write and pop leaves LEVEL_O unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when LEVEL_O != 0 and synced CTS=1. On that edge the head byte is popped into the shift register and SERIAL_O goes low.
  - START: SERIAL_O=0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA: sends 8 bits LSB first, each held CLKS_PER_BIT cycles. A 3-bit index wraps 7 -> 0, then -> STOP.
  - STOP: SERIAL_O=1 for CLKS_PER_BIT cycles. DONE_O pulses in the final cycle.
  - At the end of STOP, go directly to START (popping the next byte, no idle gap) if LEVEL_O != 0 and synced CTS=1; otherwise go to IDLE.
- Flow control:
  - CTS is sampled only at frame boundaries (IDLE, or end of STOP).
  - Deasserting CTS mid-frame never truncates a frame; the current frame always completes.
- Latency: a write at edge n, into an empty FIFO with synced CTS already high, drives SERIAL_O low after edge n+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- SERIAL_O is registered (glitch-free).
- BUSY_O=1 in START, DATA and STOP.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE/START/DATA/STOP);
  - the frame constants DATA_BITS=8 and STOP_BITS=1;
  - the CLKS_PER_BIT computation function and the clog2 helper.
- One sub-module, uart_sync_fifo: parameterised synchronous FIFO providing wr/rd/full/empty/level. The top-level FSM, baud counter and CTS synchroniser instantiate it.

Test Plan:
All scenarios use CLK_HZ=1000, BAUD=100, so CLKS_PER_BIT=10 and one frame is 100 cycles.
- Single byte: CTS=1, write 0xA5 -> SERIAL_O low after 2 edges. Sampling at bit centres reads 0, 1,0,1,0,0,1,0,1, 1. DONE_O pulses once, at frame cycle 100.
- Back-to-back: write 0x00, 0xFF, 0x55 consecutively -> three contiguous frames, no idle cycles between them, 300 cycles total, LEVEL_O sequence 3 -> 2 -> 1 -> 0.
- Flow control: hold CTS=0, write 0x3C -> SERIAL_O stays 1, LEVEL_O=1. Raise CTS -> frame starts 3 edges later (2 synchroniser stages + FSM). Drop CTS at frame cycle 40 -> frame completes and no next frame starts.
- Overflow: CTS=0, write 17 bytes -> FULL_O=1 after the 16th, the 17th is dropped, OVF_O=1. Raise CTS -> exactly 16 frames carrying bytes 1..16 in order.
- Reset mid-frame: assert RST_I at frame cycle 35 -> SERIAL_O=1 and LEVEL_O=0 immediately, without waiting for a clock edge. After release, no frame is transmitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame shape
// and the constant functions used to size counters.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data and occupancy count.
// Writes when full and reads when empty are ignored.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW = 8,
    localparam int AW = clog2(DEPTH),
    localparam int LW = AW + 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          wr_en_s;
    logic          rd_en_s;

    assign full    = (level_r == LW'(DEPTH));
    assign empty   = (level_r == {LW{1'b0}});
    assign wr_en_s = wr & ~full;
    assign rd_en_s = rd & ~empty;
    assign rd_data = mem_r[rd_ptr_r];
    assign level   = level_r;

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   level_r <= level_r + {{(LW-1){1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{(LW-1){1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_flow.sv
// Buffered 8N1 UART transmitter with CTS flow control; CTS is only honoured
// at frame boundaries so a started frame always completes.
module uart_tx_flow
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD = 115200,
    parameter int FIFO_DEPTH = 16,
    localparam int LEVEL_W = clog2(FIFO_DEPTH) + 1
)(
    input  logic               CLK_100_I,
    input  logic               RST_I,
    input  logic [7:0]         BYTE_I,
    input  logic               WR_I,
    input  logic               CTS_I,
    output logic               SERIAL_O,
    output logic               FULL_O,
    output logic [LEVEL_W-1:0] LEVEL_O,
    output logic               BUSY_O,
    output logic               DONE_O,
    output logic               OVF_O
);

    localparam int CPB = calc_clks_per_bit(CLK_HZ, BAUD);
    localparam int BW  = clog2(CPB);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_t              state_r, state_n;
    logic [BW-1:0]          baud_cnt_r, baud_n;
    logic [2:0]             bit_idx_r, bit_n;
    logic [DATA_BITS-1:0]   shift_r, shift_n;
    logic                   serial_r, serial_n;
    logic                   done_r, done_n;
    logic                   busy_r, busy_n;
    logic                   ovf_r;
    logic                   cts_meta_r, cts_sync_r;
    logic                   pop_s;
    logic                   bit_end_s;
    logic                   can_start_s;
    logic [7:0]             head_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [LEVEL_W-1:0]     fifo_level_s;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (8)
    ) u_fifo (
        .clk     (CLK_100_I),
        .rst     (RST_I),
        .wr      (WR_I),
        .wr_data (BYTE_I),
        .rd      (pop_s),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level_s)
    );

    assign bit_end_s   = (baud_cnt_r == BW'(CPB - 1));
    assign can_start_s = ~fifo_empty_s & cts_sync_r;

    // Two-stage synchroniser for the asynchronous clear-to-send input.
    always_ff @(posedge CLK_100_I or posedge RST_I) begin
        if (RST_I) begin
            cts_meta_r <= 1'b0;
            cts_sync_r <= 1'b0;
        end else begin
            cts_meta_r <= CTS_I;
            cts_sync_r <= cts_meta_r;
        end
    end

    // Sticky overflow flag, judged on the pre-edge full condition.
    always_ff @(posedge CLK_100_I or posedge RST_I) begin
        if (RST_I) begin
            ovf_r <= 1'b0;
        end else if (WR_I && fifo_full_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Transmitter state and registered line outputs.
    always_ff @(posedge CLK_100_I or posedge RST_I) begin
        if (RST_I) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= {BW{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= {DATA_BITS{1'b0}};
            serial_r   <= 1'b1;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            baud_cnt_r <= baud_n;
            bit_idx_r  <= bit_n;
            shift_r    <= shift_n;
            serial_r   <= serial_n;
            done_r     <= done_n;
            busy_r     <= busy_n;
        end
    end

    // Next-state logic; outputs are computed one cycle early so they leave flops.
    always_comb begin
        state_n  = state_r;
        baud_n   = baud_cnt_r + {{(BW-1){1'b0}}, 1'b1};
        bit_n    = bit_idx_r;
        shift_n  = shift_r;
        serial_n = serial_r;
        done_n   = 1'b0;
        pop_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                baud_n = {BW{1'b0}};
                bit_n  = 3'd0;
                if (can_start_s) begin
                    state_n  = ST_START;
                    pop_s    = 1'b1;
                    shift_n  = head_s;
                    serial_n = 1'b0;
                end else begin
                    serial_n = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_n  = ST_DATA;
                    baud_n   = {BW{1'b0}};
                    bit_n    = 3'd0;
                    serial_n = shift_r[0];
                    shift_n  = {1'b0, shift_r[DATA_BITS-1:1]};
                end else begin
                    serial_n = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_n = {BW{1'b0}};
                    bit_n  = bit_idx_r + 3'd1;
                    if (bit_idx_r == LAST_DATA) begin
                        state_n  = ST_STOP;
                        serial_n = 1'b1;
                    end else begin
                        serial_n = shift_r[0];
                        shift_n  = {1'b0, shift_r[DATA_BITS-1:1]};
                    end
                end else begin
                    serial_n = serial_r;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_n = {BW{1'b0}};
                    if (bit_idx_r == LAST_STOP) begin
                        bit_n = 3'd0;
                        if (can_start_s) begin
                            state_n  = ST_START;
                            pop_s    = 1'b1;
                            shift_n  = head_s;
                            serial_n = 1'b0;
                        end else begin
                            state_n  = ST_IDLE;
                            serial_n = 1'b1;
                        end
                    end else begin
                        bit_n = bit_idx_r + 3'd1;
                    end
                end else begin
                    done_n = (baud_cnt_r == BW'(CPB - 2)) && (bit_idx_r == LAST_STOP);
                end
            end
            default: begin
                state_n  = ST_IDLE;
                baud_n   = {BW{1'b0}};
                serial_n = 1'b1;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    assign SERIAL_O = serial_r;
    assign FULL_O   = fifo_full_s;
    assign LEVEL_O  = fifo_level_s;
    assign BUSY_O   = busy_r;
    assign DONE_O   = done_r;
    assign OVF_O    = ovf_r;

endmodule

// File: tb/tb_uart_tx_flow.sv
// Directed self-checking bench for uart_tx_flow at CLKS_PER_BIT=10 (100-cycle frames).
module tb_uart_tx_flow;

    logic       clk;
    logic       rst;
    logic [7:0] byte_in;
    logic       wr;
    logic       cts;
    logic       serial;
    logic       full;
    logic [4:0] level;
    logic       busy;
    logic       done;
    logic       ovf;

    int checks = 0;
    int failures = 0;

    uart_tx_flow #(
        .CLK_HZ     (1000),
        .BAUD       (100),
        .FIFO_DEPTH (16)
    ) dut (
        .CLK_100_I (clk),
        .RST_I     (rst),
        .BYTE_I    (byte_in),
        .WR_I      (wr),
        .CTS_I     (cts),
        .SERIAL_O  (serial),
        .FULL_O    (full),
        .LEVEL_O   (level),
        .BUSY_O    (busy),
        .DONE_O    (done),
        .OVF_O     (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr  = 1'b0;
        cts = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic write_byte(input logic [7:0] b);
        byte_in = b;
        wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    // Called in frame cycle 1 (just after the start edge); returns in cycle 101.
    task automatic frame_check(input logic [7:0] b, input string tag, input int drop_cts_at);
        logic [9:0] exp_bits;
        int done_cnt;
        int done_at;
        exp_bits = {1'b1, b, 1'b0};
        done_cnt = 0;
        done_at = 0;
        for (int c = 1; c <= 100; c++) begin
            if (c == drop_cts_at) cts = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            if ((c - 1) % 10 == 4)
                check($sformatf("%s_bit%0d", tag, (c - 1) / 10), serial, exp_bits[(c - 1) / 10]);
            tick();
        end
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_at, 100);
    endtask

    initial begin
        int high_cycles;
        rst = 1'b1;
        byte_in = 8'h00;
        wr = 1'b0;
        cts = 1'b0;
        tick();
        tick();
        check("rst_serial", serial, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();

        // Single byte, CTS already synchronised high.
        cts = 1'b1;
        tick(); tick(); tick();
        write_byte(8'hA5);
        check("single_level_after_wr", level, 1);
        check("single_serial_before_start", serial, 1);
        tick();
        check("single_serial_start", serial, 0);
        check("single_busy", busy, 1);
        check("single_level_popped", level, 0);
        frame_check(8'hA5, "single", 0);
        check("single_idle_serial", serial, 1);
        check("single_idle_busy", busy, 0);

        // Back-to-back: three queued bytes go out as contiguous frames.
        do_reset();
        write_byte(8'h00);
        write_byte(8'hFF);
        write_byte(8'h55);
        check("b2b_level3", level, 3);
        cts = 1'b1;
        tick(); tick();
        check("b2b_serial_sync_wait", serial, 1);
        tick();
        check("b2b_start0", serial, 0);
        check("b2b_level2", level, 2);
        frame_check(8'h00, "b2b_f0", 0);
        check("b2b_start1", serial, 0);
        check("b2b_level1", level, 1);
        frame_check(8'hFF, "b2b_f1", 0);
        check("b2b_start2", serial, 0);
        check("b2b_level0", level, 0);
        frame_check(8'h55, "b2b_f2", 0);
        check("b2b_end_busy", busy, 0);
        check("b2b_end_serial", serial, 1);

        // Flow control: hold-off, 3-edge start latency, mid-frame drop.
        do_reset();
        write_byte(8'h3C);
        tick(); tick(); tick(); tick(); tick();
        check("fc_hold_serial", serial, 1);
        check("fc_hold_level", level, 1);
        check("fc_hold_busy", busy, 0);
        write_byte(8'hC3);
        check("fc_level2", level, 2);
        cts = 1'b1;
        tick(); tick();
        check("fc_serial_2edges", serial, 1);
        tick();
        check("fc_start_3edges", serial, 0);
        frame_check(8'h3C, "fc", 40);
        check("fc_after_serial", serial, 1);
        check("fc_after_busy", busy, 0);
        check("fc_after_level", level, 1);
        for (int i = 0; i < 20; i++) tick();
        check("fc_still_idle", serial, 1);
        check("fc_still_level", level, 1);

        // Overflow: 17 writes into a 16-deep FIFO.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            byte_in = 8'(i);
            wr = 1'b1;
            tick();
            if (i == 15) check("ovf_not_full_15", full, 0);
            if (i == 16) begin
                check("ovf_full_16", full, 1);
                check("ovf_level_16", level, 16);
                check("ovf_clear_16", ovf, 0);
            end
        end
        wr = 1'b0;
        check("ovf_set", ovf, 1);
        check("ovf_level_kept", level, 16);
        check("ovf_full_kept", full, 1);
        cts = 1'b1;
        tick(); tick(); tick();
        check("ovf_first_start", serial, 0);
        for (int k = 1; k <= 16; k++) begin
            frame_check(8'(k), $sformatf("ovf_f%0d", k), 0);
            if (k < 16) check($sformatf("ovf_contig%0d", k), serial, 0);
        end
        check("ovf_end_level", level, 0);
        check("ovf_end_busy", busy, 0);
        check("ovf_end_full", full, 0);
        check("ovf_sticky", ovf, 1);

        // Asynchronous reset in the middle of a frame.
        do_reset();
        cts = 1'b1;
        tick(); tick(); tick();
        write_byte(8'h5A);
        write_byte(8'h77);
        check("rmf_start", serial, 0);
        check("rmf_level", level, 1);
        for (int i = 0; i < 34; i++) tick();
        check("rmf_mid_frame_low", serial, 0);
        #2;
        rst = 1'b1;
        #1;
        check("rmf_async_serial", serial, 1);
        check("rmf_async_level", level, 0);
        check("rmf_async_busy", busy, 0);
        tick();
        rst = 1'b0;
        high_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (serial === 1'b1) high_cycles++;
        end
        check("rmf_no_frame", high_cycles, 200);
        check("rmf_level_after", level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
